mesh_port_arbiter: RTL and testbench

Round-robin arbiter that shares one outgoing mesh link between several input FIFOs of a mesh router node. It pops one packet at a time from the pending requesters and holds it in a single-entry output register. It presents that register to the downstream link with the same pending/pop handshake the mesh FIFOs use. It sits between the router's per-direction input FIFOs and one output port of the mesh wrapper.

---
 rtl/mesh_arb_pkg.sv | 17 +
 rtl/mesh_rr_pick.sv | 37 +++
 rtl/mesh_port_arbiter.sv | 118 +++++++++++
 tb/tb_mesh_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared types and constants for the mesh output-port arbiter.
// The grant_cnt statistics port is only built when MESH_ARB_STATS_EN is defined.
package mesh_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  localparam int DEFAULT_PCKG_SZ = 40;

  // Width of an index into n requesters; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mesh_rr_pick.sv
// Combinational round-robin picker: the first requester at or after
// last_grant+1 (wrapping modulo NUM_IN) wins.
module mesh_rr_pick
  import mesh_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_valid
);

  int               cand_i;
  logic [IDX_W-1:0] cand;

  // Offsets run 1..NUM_IN so the last requester granted is considered last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand_i    = 0;
    cand      = '0;
    for (int off = 1; off <= NUM_IN; off++) begin
      cand_i = (int'(last_grant) + off) % NUM_IN;
      cand   = IDX_W'(cand_i);
      if (!any_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter sharing one mesh output link between NUM_IN input FIFOs.
// Optional per-requester grant counters on grant_cnt when MESH_ARB_STATS_EN is defined.
module mesh_port_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int PCKG_SZ = DEFAULT_PCKG_SZ,
  parameter int NUM_IN  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           pndng_in,
  input  logic [NUM_IN*PCKG_SZ-1:0]   data_in,
  output logic [NUM_IN-1:0]           pop_in,
  output logic [PCKG_SZ-1:0]          data_out,
  output logic                        pndng_out,
  input  logic                        pop_out,
  output logic [$clog2(NUM_IN)-1:0]   grant_id
`ifdef MESH_ARB_STATS_EN
  ,
  output logic [NUM_IN*16-1:0]        grant_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_IN);

  // Handshake (both sides): pndng means "a valid packet is on data now";
  // pop is a one-cycle strobe meaning "that packet is taken at this edge".
  // A producer holds pndng and data stable until it sees pop.

  arb_state_t        state;
  logic [IDX_W-1:0]  last_grant;

  logic [NUM_IN-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_valid;
  logic              pick;
  logic [PCKG_SZ-1:0] sel_data;

  mesh_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req        (pndng_in),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  assign pick   = any_valid && ((state == IDLE) || pop_out) && !reset;
  assign pop_in = pick ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) sel_data = data_in[i*PCKG_SZ +: PCKG_SZ];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pndng_out  <= 1'b0;
      data_out   <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state      <= FULL;
            pndng_out  <= 1'b1;
            data_out   <= sel_data;
            grant_id   <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        FULL: begin
          // Refill in the same cycle the held packet leaves, so a
          // continuously requesting set of FIFOs sustains one packet per cycle.
          if (pop_out) begin
            if (any_valid) begin
              data_out   <= sel_data;
              grant_id   <= grant_idx;
              last_grant <= grant_idx;
            end else begin
              state     <= IDLE;
              pndng_out <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pndng_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef MESH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (reset) begin
        grant_cnt[i*16 +: 16] <= '0;
      end else if (pick && grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

  a_pop_onehot : assert property (@(posedge clk) $onehot0(pop_in));
  a_pop_reset  : assert property (@(posedge clk) reset |-> (pop_in == '0));
  a_pop_hold   : assert property (@(posedge clk)
                   (state == FULL && !pop_out) |-> (pop_in == '0));
  a_out_state  : assert property (@(posedge clk) pndng_out == (state == FULL));

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter with a round-robin reference model.
// Define MESH_ARB_STATS_EN for both RTL and bench to cover grant_cnt.
module tb_mesh_port_arbiter;

  localparam int N  = 4;
  localparam int PW = 40;

  logic            clk;
  logic            reset;
  logic [N-1:0]    pndng_in;
  logic [N*PW-1:0] data_in;
  logic [N-1:0]    pop_in;
  logic [PW-1:0]   data_out;
  logic            pndng_out;
  logic            pop_out;
  logic [1:0]      grant_id;
`ifdef MESH_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mesh_port_arbiter #(
    .PCKG_SZ (PW),
    .NUM_IN  (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng_in  (pndng_in),
    .data_in   (data_in),
    .pop_in    (pop_in),
    .data_out  (data_out),
    .pndng_out (pndng_out),
    .pop_out   (pop_out),
    .grant_id  (grant_id)
`ifdef MESH_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester found going upward from last+1, wrapping.
  function automatic int pick_model(input logic [N-1:0] req, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  bit          started = 0;
  bit          m_full  = 0;
  logic [PW-1:0] m_data = '0;
  int          m_id   = 0;
  int          m_last = N - 1;
  int          m_cnt [N];

  always @(posedge clk) begin
    int p;
    p = pick_model(pndng_in, m_last);
    if (reset) begin
      m_full = 0;
      m_data = '0;
      m_id   = 0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if ((!m_full || pop_out) && p >= 0) begin
      m_full = 1;
      m_data = data_in[p*PW +: PW];
      m_id   = p;
      m_last = p;
      if (m_cnt[p] < 65535) m_cnt[p] = m_cnt[p] + 1;
    end else if (m_full && pop_out) begin
      m_full = 0;
    end
    started = 1;
  end

  // One compare process, mid-cycle, against the model.
  always @(negedge clk) begin
    int p;
    logic [N-1:0] exp_pop;
    if (started) begin
      p = pick_model(pndng_in, m_last);
      exp_pop = '0;
      if (!reset && (!m_full || pop_out) && p >= 0) exp_pop = 4'b0001 << p;
      chk("model_pop_in", {60'd0, pop_in}, {60'd0, exp_pop});
      chk("model_pndng_out", {63'd0, pndng_out}, {63'd0, m_full});
      if (m_full) begin
        chk("model_data_out", {24'd0, data_out}, {24'd0, m_data});
        chk("model_grant_id", {62'd0, grant_id}, 64'(m_id));
      end
`ifdef MESH_ARB_STATS_EN
      for (int i = 0; i < N; i++)
        chk("model_grant_cnt", {48'd0, grant_cnt[i*16 +: 16]}, 64'(m_cnt[i]));
`endif
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs just after the rising edge, return mid-cycle.
  task automatic cycle(input logic r, input logic [N-1:0] p, input logic po);
    @(posedge clk);
    #1;
    reset    = r;
    pndng_in = p;
    pop_out  = po;
    @(negedge clk);
  endtask

  localparam logic [PW-1:0] PKT0 = 40'h11_2233_4455;
  localparam logic [PW-1:0] PKT1 = 40'hAA_BBCC_DDEE;
  localparam logic [PW-1:0] PKT2 = 40'h00_0000_00A5;
  localparam logic [PW-1:0] PKT3 = 40'hF0_0F0F_F0F0;

  logic [N-1:0] tv_req [12];
  logic         tv_pop [12];

  initial begin
    reset    = 1'b1;
    pndng_in = '0;
    pop_out  = 1'b0;
    data_in  = {PKT3, PKT2, PKT1, PKT0};

    // Reset state, including requests and pop_out asserted during reset.
    cycle(1, 4'b0000, 0);
    cycle(1, 4'b1111, 1);
    chk("rst_pop_in", {60'd0, pop_in}, 64'h0);
    chk("rst_pndng_out", {63'd0, pndng_out}, 64'h0);
    chk("rst_data_out", {24'd0, data_out}, 64'h0);
    chk("rst_grant_id", {62'd0, grant_id}, 64'h0);

    // Single request from requester 2.
    cycle(0, 4'b0100, 0);
    chk("single_pop_in", {60'd0, pop_in}, 64'h4);
    chk("single_idle", {63'd0, pndng_out}, 64'h0);
    cycle(0, 4'b0000, 0);
    chk("single_pndng_out", {63'd0, pndng_out}, 64'h1);
    chk("single_data_out", {24'd0, data_out}, 64'hA5);
    chk("single_grant_id", {62'd0, grant_id}, 64'h2);
    chk("single_no_repop", {60'd0, pop_in}, 64'h0);
    cycle(0, 4'b0000, 1);
    cycle(0, 4'b0000, 0);
    chk("drain_pndng_out", {63'd0, pndng_out}, 64'h0);
    cycle(0, 4'b0000, 1);
    cycle(0, 4'b0000, 0);
    chk("idle_pop_ignored", {63'd0, pndng_out}, 64'h0);

    // Full contention from a fresh reset: grants 0,1,2,3,0,1.
    cycle(1, 4'b0000, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 4'b1111, 1);
      chk("rr_pop_in", {60'd0, pop_in}, 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_pndng_out", {63'd0, pndng_out}, 64'h1);
        chk("rr_grant_id", {62'd0, grant_id}, 64'((k - 1) % 4));
      end
    end

    // Backpressure: requester 1's packet held for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      cycle(0, 4'b0011, 0);
      chk("bp_pop_in", {60'd0, pop_in}, 64'h0);
      chk("bp_data_out", {24'd0, data_out}, {24'd0, PKT1});
      chk("bp_grant_id", {62'd0, grant_id}, 64'h1);
    end
    cycle(0, 4'b0011, 1);
    chk("bp_release_pop", {60'd0, pop_in}, 64'h1);
    cycle(0, 4'b0010, 0);
    chk("bp_next_data", {24'd0, data_out}, {24'd0, PKT0});
    chk("bp_next_id", {62'd0, grant_id}, 64'h0);
    cycle(0, 4'b0000, 1);
    chk("dropped_req_pop", {60'd0, pop_in}, 64'h0);
    cycle(0, 4'b0000, 0);
    chk("bp_drained", {63'd0, pndng_out}, 64'h0);

    // Wrap-around: bring last_grant to 3, then request 0 and 3 together.
    cycle(0, 4'b1000, 0);
    chk("wrap_setup_pop", {60'd0, pop_in}, 64'h8);
    cycle(0, 4'b0000, 1);
    chk("wrap_setup_id", {62'd0, grant_id}, 64'h3);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b1001, 0);
    chk("wrap_first_pop", {60'd0, pop_in}, 64'h1);
    cycle(0, 4'b1000, 1);
    chk("wrap_first_id", {62'd0, grant_id}, 64'h0);
    chk("wrap_second_pop", {60'd0, pop_in}, 64'h8);
    cycle(0, 4'b0000, 1);
    chk("wrap_second_id", {62'd0, grant_id}, 64'h3);
    cycle(0, 4'b0000, 0);

    // Reset while FULL with requests pending.
    cycle(0, 4'b1111, 0);
    chk("mid_first_pop", {60'd0, pop_in}, 64'h1);
    cycle(0, 4'b1110, 0);
    cycle(1, 4'b1110, 1);
    chk("mid_rst_pop_in", {60'd0, pop_in}, 64'h0);
    cycle(0, 4'b1111, 0);
    chk("mid_rst_pndng_out", {63'd0, pndng_out}, 64'h0);
    chk("mid_rst_prefer0", {60'd0, pop_in}, 64'h1);
    cycle(0, 4'b1110, 1);
    chk("mid_rst_id", {62'd0, grant_id}, 64'h0);
    chk("mid_rst_next_pop", {60'd0, pop_in}, 64'h2);
    cycle(0, 4'b0000, 1);
    cycle(0, 4'b0000, 0);

    // Mixed directed vectors with changing packet contents; model checks these.
    tv_req = '{4'b0110, 4'b0110, 4'b0100, 4'b1010, 4'b1010, 4'b0000,
               4'b0001, 4'b1101, 4'b1100, 4'b1100, 4'b0101, 4'b0000};
    tv_pop = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < N; j++)
        data_in[j*PW +: PW] = 40'hD0_0000_0000 | 40'(i * 16 + j);
      cycle(0, tv_req[i], tv_pop[i]);
    end
    cycle(0, 4'b0000, 1);
    cycle(0, 4'b0000, 0);

`ifdef MESH_ARB_STATS_EN
    // Counter saturation: 70000 grants to requester 1.
    cycle(1, 4'b0000, 0);
    for (int k = 0; k < 70000; k++) cycle(0, 4'b0010, 1);
    cycle(0, 4'b0000, 1);
    cycle(0, 4'b0000, 0);
    chk("cnt0_zero", {48'd0, grant_cnt[15:0]}, 64'h0);
    chk("cnt1_sat", {48'd0, grant_cnt[31:16]}, 64'hFFFF);
    chk("cnt2_zero", {48'd0, grant_cnt[47:32]}, 64'h0);
    chk("cnt3_zero", {48'd0, grant_cnt[63:48]}, 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
